// File: rtl/fft_btf_sched.sv
// Address/strobe scheduler for an in-place radix-2 DIF FFT: walks every stage
// issuing N/2 butterflies, then drains the butterfly pipeline before the next stage.
module fft_btf_sched #(
  parameter int LOG2N   = 10,
  parameter int RD_LAT  = 1,
  parameter int BTF_LAT = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [LOG2N-1:0] stage_o,
  output logic             rd_en_o,
  output logic [LOG2N-1:0] rd_addr_a_o,
  output logic [LOG2N-1:0] rd_addr_b_o,
  output logic [LOG2N-2:0] tw_addr_o,
  output logic             wr_en_o,
  output logic [LOG2N-1:0] wr_addr_a_o,
  output logic [LOG2N-1:0] wr_addr_b_o,
  output logic [1:0]       dbg_state_o
);

  localparam int N        = 1 << LOG2N;
  localparam int AW       = LOG2N;
  localparam int HW       = LOG2N - 1;
  localparam int PIPE_LAT = RD_LAT + BTF_LAT;
  localparam int DW       = $clog2(PIPE_LAT) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW-1:0] HALF       = AW'(N / 2);
  localparam logic [AW-1:0] ONE        = AW'(1);
  localparam logic [AW-1:0] LAST_STAGE = AW'(LOG2N - 1);
  localparam logic [AW-1:0] LOG2N_V    = AW'(LOG2N);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] stage_q, stage_d;
  logic [HW-1:0] g_q, g_d;
  logic [HW-1:0] k_q, k_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  logic [AW-1:0] span, groups, base, addr_a, addr_b;
  logic [HW-1:0] tw;
  logic          last_k, last_g, drain_end, issue;

  // Handshake: start_i is a one-cycle request with no ready; it is honoured
  // only in IDLE, and busy_o high means any start_i is dropped.
  always_comb begin
    span      = HALF >> stage_q;
    groups    = ONE << stage_q;
    base      = {1'b0, g_q} << (LOG2N_V - stage_q);
    addr_a    = base | {1'b0, k_q};
    addr_b    = addr_a + span;
    tw        = k_q << stage_q;
    last_k    = ({1'b0, k_q} == (span - ONE));
    last_g    = ({1'b0, g_q} == (groups - ONE));
    drain_end = (dcnt_q == DW'(PIPE_LAT - 1));
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    g_d     = g_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_ISSUE;
          stage_d = '0;
          g_d     = '0;
          k_d     = '0;
        end
      end
      S_ISSUE: begin
        if (last_k) begin
          k_d = '0;
          if (last_g) begin
            g_d     = '0;
            dcnt_d  = '0;
            state_d = S_DRAIN;
          end else begin
            g_d = g_q + HW'(1);
          end
        end else begin
          k_d = k_q + HW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_end) begin
          dcnt_d = '0;
          if (stage_q != LAST_STAGE) begin
            stage_d = stage_q + ONE;
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        stage_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      g_q     <= '0;
      k_q     <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      g_q     <= g_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign issue       = (state_q == S_ISSUE);
  assign rd_en_o     = issue;
  assign rd_addr_a_o = issue ? addr_a : '0;
  assign rd_addr_b_o = issue ? addr_b : '0;
  assign tw_addr_o   = issue ? tw : '0;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign stage_o     = stage_q;
  assign dbg_state_o = state_q;

  // Write-back tracker: shifts every cycle, so a reset flushes in-flight writes.
  logic          vld_q [PIPE_LAT];
  logic [AW-1:0] pa_q  [PIPE_LAT];
  logic [AW-1:0] pb_q  [PIPE_LAT];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        vld_q[i] <= 1'b0;
        pa_q[i]  <= '0;
        pb_q[i]  <= '0;
      end
    end else begin
      vld_q[0] <= rd_en_o;
      pa_q[0]  <= rd_addr_a_o;
      pb_q[0]  <= rd_addr_b_o;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        pa_q[i]  <= pa_q[i-1];
        pb_q[i]  <= pb_q[i-1];
      end
    end
  end

  assign wr_en_o     = vld_q[PIPE_LAT-1];
  assign wr_addr_a_o = pa_q[PIPE_LAT-1];
  assign wr_addr_b_o = pb_q[PIPE_LAT-1];

endmodule

// File: tb/tb_fft_btf_sched.sv
// Bench for fft_btf_sched: three instances (LOG2N=3, LOG2N=10, LOG2N=3 with a
// longer pipeline) checked every cycle against a schedule model plus literal runs.
module tb_fft_btf_sched;

  typedef struct packed {
    logic [11:0] rd, ra, rb, tw, wr, wa, wb, busy, done, stage, st;
  } obs_t;

  int PL [3] = '{3, 10, 3};
  int PP [3] = '{4, 4, 7};

  logic clk = 1'b0;
  logic rst_v   [3];
  logic start_v [3];
  obs_t obs [3];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   chk_en = 1'b0;
  int   act [3];
  int   tt  [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT instances ----------------
  logic       d0_busy, d0_done, d0_rd, d0_wr;
  logic [2:0] d0_stage, d0_ra, d0_rb, d0_wa, d0_wb;
  logic [1:0] d0_tw, d0_st;
  fft_btf_sched #(.LOG2N(3)) u0 (
    .clk_i(clk), .rst_i(rst_v[0]), .start_i(start_v[0]), .busy_o(d0_busy), .done_o(d0_done),
    .stage_o(d0_stage), .rd_en_o(d0_rd), .rd_addr_a_o(d0_ra), .rd_addr_b_o(d0_rb),
    .tw_addr_o(d0_tw), .wr_en_o(d0_wr), .wr_addr_a_o(d0_wa), .wr_addr_b_o(d0_wb),
    .dbg_state_o(d0_st));
  assign obs[0] = {12'(d0_rd), 12'(d0_ra), 12'(d0_rb), 12'(d0_tw), 12'(d0_wr), 12'(d0_wa),
                   12'(d0_wb), 12'(d0_busy), 12'(d0_done), 12'(d0_stage), 12'(d0_st)};

  logic       d1_busy, d1_done, d1_rd, d1_wr;
  logic [9:0] d1_stage, d1_ra, d1_rb, d1_wa, d1_wb;
  logic [8:0] d1_tw;
  logic [1:0] d1_st;
  fft_btf_sched #(.LOG2N(10)) u1 (
    .clk_i(clk), .rst_i(rst_v[1]), .start_i(start_v[1]), .busy_o(d1_busy), .done_o(d1_done),
    .stage_o(d1_stage), .rd_en_o(d1_rd), .rd_addr_a_o(d1_ra), .rd_addr_b_o(d1_rb),
    .tw_addr_o(d1_tw), .wr_en_o(d1_wr), .wr_addr_a_o(d1_wa), .wr_addr_b_o(d1_wb),
    .dbg_state_o(d1_st));
  assign obs[1] = {12'(d1_rd), 12'(d1_ra), 12'(d1_rb), 12'(d1_tw), 12'(d1_wr), 12'(d1_wa),
                   12'(d1_wb), 12'(d1_busy), 12'(d1_done), 12'(d1_stage), 12'(d1_st)};

  logic       d2_busy, d2_done, d2_rd, d2_wr;
  logic [2:0] d2_stage, d2_ra, d2_rb, d2_wa, d2_wb;
  logic [1:0] d2_tw, d2_st;
  fft_btf_sched #(.LOG2N(3), .RD_LAT(2), .BTF_LAT(5)) u2 (
    .clk_i(clk), .rst_i(rst_v[2]), .start_i(start_v[2]), .busy_o(d2_busy), .done_o(d2_done),
    .stage_o(d2_stage), .rd_en_o(d2_rd), .rd_addr_a_o(d2_ra), .rd_addr_b_o(d2_rb),
    .tw_addr_o(d2_tw), .wr_en_o(d2_wr), .wr_addr_a_o(d2_wa), .wr_addr_b_o(d2_wb),
    .dbg_state_o(d2_st));
  assign obs[2] = {12'(d2_rd), 12'(d2_ra), 12'(d2_rb), 12'(d2_tw), 12'(d2_wr), 12'(d2_wa),
                   12'(d2_wb), 12'(d2_busy), 12'(d2_done), 12'(d2_stage), 12'(d2_st)};

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input int idx, input logic [11:0] got, input logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", nm, idx, cyc, got, exp);
    end
  endtask

  // Butterfly j of stage s, straight from the radix-2 DIF index rules.
  function automatic void bfly(input int L, input int s, input int j,
                               output int a, output int b, output int tw);
    int span, g, k;
    span = (1 << L) >> (s + 1);
    g    = j / span;
    k    = j % span;
    a    = g * 2 * span + k;
    b    = a + span;
    tw   = k * (1 << s);
  endfunction

  // Expected outputs t cycles after an accepted start (t=1 is the first issue cycle).
  function automatic obs_t model(input int L, input int P, input int active, input int t);
    obs_t e;
    int half, slen, tend, u, s, r, a, b, w;
    e    = '0;
    half = (1 << L) / 2;
    slen = half + P;
    tend = L * slen;
    if (active == 0) return e;
    e.busy = 12'd1;
    if (t <= tend) begin
      u = t - 1; s = u / slen; r = u % slen;
      e.stage = 12'(s);
      e.st    = (r < half) ? 12'd1 : 12'd2;
      if (r < half) begin
        bfly(L, s, r, a, b, w);
        e.rd = 12'd1; e.ra = 12'(a); e.rb = 12'(b); e.tw = 12'(w);
      end
    end else begin
      e.done = 12'd1; e.stage = 12'(L - 1); e.st = 12'd3;
    end
    if (t - P >= 1 && t - P <= tend) begin
      u = t - P - 1; s = u / slen; r = u % slen;
      if (r < half) begin
        bfly(L, s, r, a, b, w);
        e.wr = 12'd1; e.wa = 12'(a); e.wb = 12'(b);
      end
    end
    return e;
  endfunction

  initial for (int i = 0; i < 3; i++) begin act[i] = 0; tt[i] = 0; end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_v[i]) act[i] = 0;
      else if (act[i] != 0) begin
        if (tt[i] == PL[i] * ((1 << PL[i]) / 2 + PP[i]) + 1) act[i] = 0;
        else tt[i] = tt[i] + 1;
      end else if (start_v[i]) begin
        act[i] = 1; tt[i] = 1;
      end
    end
  end

  // Single compare process: every DUT, every cycle after reset.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        obs_t e;
        e = model(PL[i], PP[i], act[i], tt[i]);
        chk("rd_en", i, obs[i].rd, e.rd);
        chk("rd_addr_a", i, obs[i].ra, e.ra);
        chk("rd_addr_b", i, obs[i].rb, e.rb);
        chk("tw_addr", i, obs[i].tw, e.tw);
        chk("wr_en", i, obs[i].wr, e.wr);
        if (e.wr[0] || act[i] == 0) begin
          chk("wr_addr_a", i, obs[i].wa, e.wa);
          chk("wr_addr_b", i, obs[i].wb, e.wb);
        end
        chk("busy", i, obs[i].busy, e.busy);
        chk("done", i, obs[i].done, e.done);
        chk("stage", i, obs[i].stage, e.stage);
        chk("state", i, obs[i].st, e.st);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Hand-written LOG2N=3 schedule: rd pairs with twiddle; writes trail by 4.
  function automatic void lit_rd(input int c, output int en, output int a, output int b, output int tw);
    en = 1; a = 0; b = 0; tw = 0;
    case (c)
      1:  begin a = 0; b = 4; tw = 0; end
      2:  begin a = 1; b = 5; tw = 1; end
      3:  begin a = 2; b = 6; tw = 2; end
      4:  begin a = 3; b = 7; tw = 3; end
      9:  begin a = 0; b = 2; tw = 0; end
      10: begin a = 1; b = 3; tw = 2; end
      11: begin a = 4; b = 6; tw = 0; end
      12: begin a = 5; b = 7; tw = 2; end
      17: begin a = 0; b = 1; tw = 0; end
      18: begin a = 2; b = 3; tw = 0; end
      19: begin a = 4; b = 5; tw = 0; end
      20: begin a = 6; b = 7; tw = 0; end
      default: en = 0;
    endcase
  endfunction

  task automatic lit_run();
    int en, a, b, tw, wen, wa, wb, wtw;
    for (int c = 0; c <= 26; c++) begin
      start_v[0] = (c == 0);
      @(negedge clk);
      if (c >= 1) begin
        lit_rd(c, en, a, b, tw);
        lit_rd(c - 4, wen, wa, wb, wtw);
        chk("lit_rd_en", 0, 12'(d0_rd), 12'(en));
        chk("lit_rd_a", 0, 12'(d0_ra), 12'(a));
        chk("lit_rd_b", 0, 12'(d0_rb), 12'(b));
        chk("lit_tw", 0, 12'(d0_tw), 12'(tw));
        chk("lit_wr_en", 0, 12'(d0_wr), 12'(wen));
        if (wen != 0) begin
          chk("lit_wr_a", 0, 12'(d0_wa), 12'(wa));
          chk("lit_wr_b", 0, 12'(d0_wb), 12'(wb));
        end
        chk("lit_busy", 0, 12'(d0_busy), (c <= 25) ? 12'd1 : 12'd0);
        chk("lit_done", 0, 12'(d0_done), (c == 25) ? 12'd1 : 12'd0);
      end
      next_cycle();
    end
  endtask

  initial begin
    int rd_n, wr_n, done_c, first_wr, drain_n, gap, abort_at, idx, tot;
    for (int i = 0; i < 3; i++) begin rst_v[i] = 1'b1; start_v[i] = 1'b0; end
    repeat (3) next_cycle();
    @(negedge clk);
    chk("reset_busy", 0, 12'(d0_busy), 12'd0);
    chk("reset_wr_en", 0, 12'(d0_wr), 12'd0);
    chk("reset_stage", 1, 12'(d1_stage), 12'd0);
    next_cycle();
    for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
    chk_en = 1'b1;
    next_cycle();

    // Reference schedule for LOG2N=3
    lit_run();

    // Starts during a run are dropped; a start straight after DONE is taken.
    for (int c = 0; c <= 53; c++) begin
      start_v[0] = (c == 0 || c == 3 || c == 12 || c == 25 || c == 26);
      @(negedge clk);
      if (c == 25) chk("ign_done25", 0, 12'(d0_done), 12'd1);
      if (c == 26) chk("ign_idle26", 0, 12'(d0_busy), 12'd0);
      if (c == 27) begin
        chk("restart_rd", 0, 12'(d0_rd), 12'd1);
        chk("restart_b", 0, 12'(d0_rb), 12'd4);
      end
      if (c == 51) chk("ign_done51", 0, 12'(d0_done), 12'd1);
      next_cycle();
    end
    start_v[0] = 1'b0;
    repeat (2) next_cycle();

    // Mid-run reset in cycle 6 aborts the transform
    for (int c = 0; c <= 9; c++) begin
      start_v[0] = (c == 0);
      rst_v[0]   = (c == 6);
      @(negedge clk);
      if (c == 7) begin
        chk("abort_wr_en", 0, 12'(d0_wr), 12'd0);
        chk("abort_busy", 0, 12'(d0_busy), 12'd0);
        chk("abort_rd_en", 0, 12'(d0_rd), 12'd0);
        chk("abort_stage", 0, 12'(d0_stage), 12'd0);
      end
      next_cycle();
    end
    lit_run();

    // LOG2N=10 totals
    rd_n = 0; wr_n = 0; done_c = -1;
    for (int c = 0; c <= 6000 && done_c < 0; c++) begin
      start_v[1] = (c == 0);
      @(negedge clk);
      if (d1_rd) rd_n++;
      if (d1_wr) wr_n++;
      if (d1_done) done_c = c;
      next_cycle();
    end
    chk("n1024_done_cycle", 1, 12'(done_c), 12'd3000 + 12'd2161);
    chk("n1024_rd_count", 1, 13'(rd_n) > 13'd4095 ? 12'(rd_n - 4096) : 12'hfff, 12'd1024);
    chk("n1024_wr_count", 1, 13'(wr_n) > 13'd4095 ? 12'(wr_n - 4096) : 12'hfff, 12'd1024);

    // Longer pipeline: RD_LAT=2, BTF_LAT=5
    done_c = -1; first_wr = -1; drain_n = 0;
    for (int c = 0; c <= 60 && done_c < 0; c++) begin
      start_v[2] = (c == 0);
      @(negedge clk);
      if (d2_wr && first_wr < 0) first_wr = c;
      if (d2_st == 2'd2) drain_n++;
      if (d2_done) done_c = c;
      next_cycle();
    end
    chk("lat7_done_cycle", 2, 12'(done_c), 12'd34);
    chk("lat7_first_wr", 2, 12'(first_wr), 12'd8);
    chk("lat7_drain_cycles", 2, 12'(drain_n), 12'd21);

    // Randomised starts, spurious starts and aborts
    for (int it = 0; it < 16; it++) begin
      idx = (it % 2 == 1) ? 2 : 0;
      tot = 3 * (4 + PP[idx]) + 1;
      gap = $urandom_range(0, 4);
      abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, tot)) : -1;
      repeat (gap) next_cycle();
      for (int c = 0; c <= tot + 1; c++) begin
        start_v[idx] = (c == 0) || ($urandom_range(0, 7) == 0);
        rst_v[idx]   = (c == abort_at);
        next_cycle();
      end
      start_v[idx] = 1'b0;
      rst_v[idx]   = 1'b0;
    end
    repeat (45) next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
